// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size codes, FSM encoding and alignment/lane helpers for the data bus master
package dmem_pkg;
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] STORE_WAIT = 2'd2;
  localparam int TIMEOUT_DEFAULT = 255;
  // Size 11 falls through to 0, so it is never treated as legal.
  function automatic logic aligned(input logic [1:0] size, input logic [1:0] addr);
    return size == SIZE_WORD ? addr == 2'b00 : size == SIZE_HALF ? !addr[0] : size == SIZE_BYTE;
  endfunction
  function automatic logic [31:0] store_lane(input logic [1:0] size, input logic [31:0] data);
    return size == SIZE_BYTE ? {24'b0, data[7:0]} : size == SIZE_HALF ? {16'b0, data[15:0]} : data;
  endfunction
endpackage

// File: rtl/load_ext.sv
// load_ext: sign/zero extension of right-justified bus load data
module load_ext
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] raw,
  output logic [31:0] result
);
  always_comb
    result = size == SIZE_BYTE ? {{24{~is_unsigned & raw[7]}}, raw[7:0]} :
             size == SIZE_HALF ? {{16{~is_unsigned & raw[15]}}, raw[15:0]} : raw;
endmodule

// File: rtl/dmem_bus_master.sv
// dmem_bus_master: turns pipeline load/store requests into handshaked data bus cycles
module dmem_bus_master
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  output logic [31:0] DAD,
  input  logic        ACKD_n,
  inout  wire  [31:0] DDT
);
  logic [1:0]  state;
  logic [31:0] wdata;
  logic [31:0] cnt;
  logic        uns;
  logic [31:0] ext;
  assign req_ready = state == IDLE;
  assign DDT = state == STORE_WAIT ? wdata : 32'bz;
  load_ext u_ext (.size(SIZE), .is_unsigned(uns), .raw(DDT), .result(ext));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      MREQ      <= 1'b0;
      WRITE     <= 1'b0;
      SIZE      <= SIZE_WORD;
      DAD       <= '0;
      wdata     <= '0;
      uns       <= 1'b0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE) begin
        if (req_valid && aligned(req_size, req_addr[1:0])) begin
          state <= req_write ? STORE_WAIT : LOAD_WAIT;
          MREQ  <= 1'b1;
          WRITE <= req_write;
          SIZE  <= req_size;
          DAD   <= req_addr;
          wdata <= store_lane(req_size, req_wdata);
          uns   <= req_unsigned;
          cnt   <= '0;
        end else if (req_valid) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end else if (!ACKD_n || cnt == 32'(TIMEOUT_CYCLES - 1)) begin
        // Ack wins over a simultaneous timeout.
        state     <= IDLE;
        MREQ      <= 1'b0;
        WRITE     <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= ACKD_n;
        if (!ACKD_n && state == LOAD_WAIT) rsp_rdata <= ext;
      end else
        cnt <= cnt + 32'd1;
    end
endmodule

// File: tb/tb_dmem_bus_master.sv
// tb_dmem_bus_master: directed checks of the data bus master with a hand-driven memory side
module tb_dmem_bus_master;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, MREQ, WRITE;
  logic [31:0] rsp_rdata, DAD;
  logic [1:0]  SIZE;
  logic        ACKD_n = 1'b1;
  logic        mem_en = 1'b0;
  logic [31:0] mem_data = '0;
  wire  [31:0] DDT;
  int vectors = 0;
  int errors = 0;
  assign DDT = mem_en ? mem_data : 32'bz;
  always #5 clk = ~clk;
  dmem_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .MREQ(MREQ), .WRITE(WRITE),
    .SIZE(SIZE), .DAD(DAD), .ACKD_n(ACKD_n), .DDT(DDT)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic req(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_size = s;
    req_unsigned = u;
    req_addr = a;
    req_wdata = d;
  endtask
  task automatic do_load(input string tag, input logic [1:0] s, input logic u, input logic [31:0] a,
                         input logic [31:0] data, input logic [31:0] exp);
    req(1'b0, s, u, a, 32'h0);
    tick();
    chk({tag, "_mreq"}, 32'(MREQ), 32'd1);
    chk({tag, "_dad"}, DAD, a);
    req_valid = 1'b0;
    ACKD_n = 1'b0;
    mem_en = 1'b1;
    mem_data = data;
    tick();
    chk({tag, "_vld"}, {30'b0, rsp_valid, MREQ}, 32'b10);
    chk({tag, "_rdata"}, rsp_rdata, exp);
    chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    ACKD_n = 1'b1;
    mem_en = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_outs", {25'b0, req_ready, rsp_valid, rsp_err, MREQ, WRITE, SIZE}, 32'b1000000);
    chk("rst_dad", DAD, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    rst = 1'b1;
    req(1'b0, 2'b00, 1'b0, 32'h0800_0010, 32'h0);
    tick();
    chk("lw_mreq", {28'b0, MREQ, WRITE, SIZE}, 32'b1000);
    chk("lw_dad", DAD, 32'h0800_0010);
    chk("lw_busy", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    ACKD_n = 1'b0;
    mem_en = 1'b1;
    mem_data = 32'hDEAD_BEEF;
    tick();
    chk("lw_done", {30'b0, rsp_valid, MREQ}, 32'b10);
    chk("lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("lw_err", 32'(rsp_err), 32'd0);
    ACKD_n = 1'b1;
    mem_en = 1'b0;
    tick();
    chk("lw_pulse", 32'(rsp_valid), 32'd0);
    chk("lw_hold", rsp_rdata, 32'hDEAD_BEEF);
    do_load("lb", 2'b10, 1'b0, 32'h0800_0003, 32'h1234_5680, 32'hFFFF_FF80);
    do_load("lbu", 2'b10, 1'b1, 32'h0800_0003, 32'h1234_5680, 32'h0000_0080);
    do_load("lh", 2'b01, 1'b0, 32'h0800_0002, 32'hABCD_8001, 32'hFFFF_8001);
    do_load("lhu", 2'b01, 1'b1, 32'h0800_0002, 32'hABCD_8001, 32'h0000_8001);
    do_load("lb_pos", 2'b10, 1'b0, 32'h0800_0001, 32'hFFFF_FF7F, 32'h0000_007F);
    req(1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'h1234_5641);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      chk($sformatf("sb_ctl%0d", i), {28'b0, MREQ, WRITE, SIZE}, 32'b1110);
      chk($sformatf("sb_dad%0d", i), DAD, 32'hF000_0000);
      chk($sformatf("sb_ddt%0d", i), DDT, 32'h0000_0041);
      chk($sformatf("sb_novld%0d", i), 32'(rsp_valid), 32'd0);
    end
    ACKD_n = 1'b0;
    tick();
    chk("sb_done", {29'b0, rsp_valid, MREQ, WRITE}, 32'b100);
    chk("sb_err", 32'(rsp_err), 32'd0);
    ACKD_n = 1'b1;
    mem_en = 1'b1;
    mem_data = 32'h0;
    #1;
    chk("sb_release", DDT, 32'h0);
    mem_en = 1'b0;
    req(1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0);
    tick();
    chk("mis_lw", {29'b0, MREQ, rsp_valid, rsp_err}, 32'b011);
    chk("mis_lw_rdata", rsp_rdata, 32'h0);
    chk("mis_lw_rdy", 32'(req_ready), 32'd1);
    req(1'b1, 2'b01, 1'b0, 32'h0800_0001, 32'h5555_AAAA);
    tick();
    chk("mis_sh", {29'b0, MREQ, rsp_valid, rsp_err}, 32'b011);
    req(1'b0, 2'b11, 1'b0, 32'h0800_0000, 32'h0);
    tick();
    chk("bad_size", {29'b0, MREQ, rsp_valid, rsp_err}, 32'b011);
    req(1'b0, 2'b00, 1'b0, 32'h0800_0020, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("to_start", 32'(MREQ), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("to_wait%0d", i), {30'b0, MREQ, rsp_valid}, 32'b10);
    end
    tick();
    chk("to_fire", {29'b0, MREQ, rsp_valid, rsp_err}, 32'b011);
    tick();
    chk("to_pulse", 32'(rsp_valid), 32'd0);
    do_load("after_to", 2'b00, 1'b0, 32'h0800_0024, 32'h1357_9BDF, 32'h1357_9BDF);
    req(1'b1, 2'b00, 1'b0, 32'h0800_0040, 32'hCAFE_F00D);
    tick();
    req_valid = 1'b0;
    chk("rs_ddt", DDT, 32'hCAFE_F00D);
    #2;
    rst = 1'b0;
    #1;
    chk("rs_mreq", {30'b0, MREQ, rsp_valid}, 32'b00);
    mem_en = 1'b1;
    mem_data = 32'h0;
    #1;
    chk("rs_release", DDT, 32'h0);
    mem_en = 1'b0;
    ACKD_n = 1'b0;
    tick();
    chk("rs_norsp", {30'b0, MREQ, rsp_valid}, 32'b00);
    chk("rs_dad", DAD, 32'h0);
    rst = 1'b1;
    req(1'b1, 2'b00, 1'b0, 32'h0800_0050, 32'h1122_3344);
    tick();
    chk("b2b_sw", {28'b0, MREQ, WRITE, SIZE}, 32'b1100);
    chk("b2b_sw_ddt", DDT, 32'h1122_3344);
    req(1'b0, 2'b00, 1'b0, 32'h0800_0054, 32'h0);
    tick();
    chk("b2b_sw_done", {29'b0, rsp_valid, req_ready, MREQ}, 32'b110);
    mem_en = 1'b1;
    mem_data = 32'h0BAD_F00D;
    tick();
    req_valid = 1'b0;
    chk("b2b_lw", {29'b0, MREQ, WRITE, rsp_valid}, 32'b100);
    chk("b2b_lw_dad", DAD, 32'h0800_0054);
    tick();
    chk("b2b_lw_done", {30'b0, rsp_valid, MREQ}, 32'b10);
    chk("b2b_lw_rdata", rsp_rdata, 32'h0BAD_F00D);
    ACKD_n = 1'b1;
    mem_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
